// File: rtl/imc_pkg.sv
// Shared types, sizes and lane helpers for the imc sequencer.
package imc_pkg;

  localparam int unsigned BANK_COUNT = 4;
  localparam int unsigned LANES      = 16;
  localparam int unsigned DW         = 4;
  localparam int unsigned RES_W      = 14;
  localparam int unsigned MAC_CYCLES = 10;
  localparam int unsigned BANK_W     = $clog2(BANK_COUNT);
  localparam int unsigned MAC_W      = $clog2(MAC_CYCLES + 1);
  localparam int unsigned VEC_W      = LANES * DW;

  typedef logic [LANES-1:0][DW-1:0] lane_vec_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    READ = 3'd2,
    MAC  = 3'd3,
    DONE = 3'd4
  } imc_state_e;

  // Lane i of a flat vector lives at bits [i*DW +: DW].
  function automatic lane_vec_t lanes_unpack(input logic [VEC_W-1:0] flat);
    return lane_vec_t'(flat);
  endfunction

  function automatic logic [VEC_W-1:0] lanes_pack(input lane_vec_t lanes);
    return VEC_W'(lanes);
  endfunction

endpackage

// File: rtl/imc_seq_ctrl.sv
// Job sequencer for the imc macro: loads weight banks, issues read, holds mac_en,
// then returns the captured result over a valid/ready handshake.
module imc_seq_ctrl
  import imc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [VEC_W-1:0]  x_data,
  input  logic              wt_valid,
  input  logic [VEC_W-1:0]  wt_data,
  output logic              wt_ready,
  output logic              write_en,
  output logic              read_en,
  output logic              mac_en,
  output logic [BANK_W-1:0] bankde,
  output lane_vec_t         Wxin,
  output lane_vec_t         Wwbank,
  input  logic [RES_W-1:0]  result,
  output logic              res_valid,
  output logic [RES_W-1:0]  res_data,
  input  logic              res_ready,
  output logic              busy
);

  imc_state_e        state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [MAC_W-1:0]  mac_q, mac_d;
  logic              wt_ready_q, wt_ready_d;
  logic              write_en_q, write_en_d;
  logic              read_en_q, read_en_d;
  logic              mac_en_q, mac_en_d;
  logic [BANK_W-1:0] bankde_q, bankde_d;
  lane_vec_t         wxin_q, wxin_d;
  lane_vec_t         wwbank_q, wwbank_d;
  logic              res_valid_q, res_valid_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic              busy_q, busy_d;

  // Next-state and registered-output computation; strobes default low every cycle.
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    mac_d       = mac_q;
    wt_ready_d  = wt_ready_q;
    write_en_d  = 1'b0;
    read_en_d   = 1'b0;
    mac_en_d    = 1'b0;
    bankde_d    = bankde_q;
    wxin_d      = wxin_q;
    wwbank_d    = wwbank_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      bank_d      = '0;
      mac_d       = '0;
      wt_ready_d  = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            wxin_d     = lanes_unpack(x_data);
            wt_ready_d = 1'b1;
            state_d    = LOAD;
          end
        end
        LOAD: begin
          if (wt_valid && wt_ready_q) begin
            write_en_d = 1'b1;
            bankde_d   = bank_q;
            wwbank_d   = lanes_unpack(wt_data);
            if (bank_q == BANK_W'(BANK_COUNT - 1)) begin
              bank_d     = '0;
              wt_ready_d = 1'b0;
              state_d    = READ;
            end else begin
              bank_d = bank_q + 1'b1;
            end
          end
        end
        READ: begin
          read_en_d = 1'b1;
          mac_d     = '0;
          state_d   = MAC;
        end
        MAC: begin
          // Capture on the edge that ends the last mac_en cycle.
          if (mac_q == MAC_W'(MAC_CYCLES)) begin
            res_data_d  = result;
            res_valid_d = 1'b1;
            mac_d       = '0;
            state_d     = DONE;
          end else begin
            mac_en_d = 1'b1;
            mac_d    = mac_q + 1'b1;
          end
        end
        DONE: begin
          if (res_ready && res_valid_q) begin
            res_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bank_q      <= '0;
      mac_q       <= '0;
      wt_ready_q  <= 1'b0;
      write_en_q  <= 1'b0;
      read_en_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      bankde_q    <= '0;
      wxin_q      <= '0;
      wwbank_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      mac_q       <= mac_d;
      wt_ready_q  <= wt_ready_d;
      write_en_q  <= write_en_d;
      read_en_q   <= read_en_d;
      mac_en_q    <= mac_en_d;
      bankde_q    <= bankde_d;
      wxin_q      <= wxin_d;
      wwbank_q    <= wwbank_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
    end
  end

  assign wt_ready  = wt_ready_q;
  assign write_en  = write_en_q;
  assign read_en   = read_en_q;
  assign mac_en    = mac_en_q;
  assign bankde    = bankde_q;
  assign Wxin      = wxin_q;
  assign Wwbank    = wwbank_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_imc_seq_ctrl.sv
// Directed bench for imc_seq_ctrl with immediate-assertion checks.
module tb_imc_seq_ctrl;
  import imc_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [VEC_W-1:0]  x_data;
  logic              wt_valid;
  logic [VEC_W-1:0]  wt_data;
  logic              wt_ready;
  logic              write_en;
  logic              read_en;
  logic              mac_en;
  logic [BANK_W-1:0] bankde;
  lane_vec_t         Wxin;
  lane_vec_t         Wwbank;
  logic [RES_W-1:0]  result;
  logic              res_valid;
  logic [RES_W-1:0]  res_data;
  logic              res_ready;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [VEC_W-1:0] xv;
  logic [VEC_W-1:0] bk [BANK_COUNT];
  logic [RES_W-1:0] golden;

  imc_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .x_data(x_data),
    .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
    .write_en(write_en), .read_en(read_en), .mac_en(mac_en), .bankde(bankde),
    .Wxin(Wxin), .Wwbank(Wwbank), .result(result), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wt_ready"}, 64'(wt_ready), 64'd0);
    chk({tag, "_write_en"}, 64'(write_en), 64'd0);
    chk({tag, "_read_en"},  64'(read_en),  64'd0);
    chk({tag, "_mac_en"},   64'(mac_en),   64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_busy"},     64'(busy),     64'd0);
  endtask

  // Start a job and stream all weight beats; optional stall of stall_len cycles after beat stall_after.
  task automatic load_job(input int stall_after, input int stall_len);
    int wr_high;
    wr_high = 0;
    start  = 1'b1;
    x_data = xv;
    tick();
    start  = 1'b0;
    x_data = '1;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_wt_ready", 64'(wt_ready), 64'd1);
    chk("start_wxin", 64'(lanes_pack(Wxin)), 64'(xv));
    wt_valid = 1'b1;
    wt_data  = bk[0];
    for (int k = 0; k < int'(BANK_COUNT); k++) begin
      tick();
      chk("load_write_en", 64'(write_en), 64'd1);
      chk("load_bankde", 64'(bankde), 64'(k));
      chk("load_wwbank", 64'(lanes_pack(Wwbank)), 64'(bk[k]));
      if (write_en) wr_high++;
      if (k < int'(BANK_COUNT) - 1) begin
        if (k == stall_after) begin
          wt_valid = 1'b0;
          for (int s = 0; s < stall_len; s++) begin
            tick();
            chk("stall_write_en", 64'(write_en), 64'd0);
            chk("stall_bankde", 64'(bankde), 64'(k));
            chk("stall_wwbank", 64'(lanes_pack(Wwbank)), 64'(bk[k]));
          end
          wt_valid = 1'b1;
        end
        wt_data = bk[k+1];
      end
    end
    wt_valid = 1'b0;
    chk("load_last_wt_ready", 64'(wt_ready), 64'd0);
    chk("load_write_count", 64'(wr_high), 64'(BANK_COUNT));
  endtask

  // READ cycle, mac_en window and result capture.
  task automatic run_mac(input logic [RES_W-1:0] exp_res);
    tick();
    chk("read_read_en", 64'(read_en), 64'd1);
    chk("read_write_en", 64'(write_en), 64'd0);
    chk("read_wt_ready", 64'(wt_ready), 64'd0);
    chk("read_mac_en", 64'(mac_en), 64'd0);
    for (int j = 0; j < int'(MAC_CYCLES); j++) begin
      tick();
      chk("mac_mac_en", 64'(mac_en), 64'd1);
      chk("mac_read_en", 64'(read_en), 64'd0);
      chk("mac_res_valid", 64'(res_valid), 64'd0);
    end
    tick();
    chk("cap_mac_en", 64'(mac_en), 64'd0);
    chk("cap_res_valid", 64'(res_valid), 64'd1);
    chk("cap_res_data", 64'(res_data), 64'(exp_res));
    chk("cap_busy", 64'(busy), 64'd1);
  endtask

  task automatic drain();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("drain_res_valid", 64'(res_valid), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; x_data = '0; wt_valid = 1'b0;
    wt_data = '0; result = '0; res_ready = 1'b0;

    for (int i = 0; i < int'(LANES); i++) begin
      xv[i*DW +: DW]    = DW'(i);
      bk[0][i*DW +: DW] = DW'(i);
      bk[1][i*DW +: DW] = DW'(15 - i);
      bk[2][i*DW +: DW] = DW'(2 * ((i % 7) + 1));
      bk[3][i*DW +: DW] = DW'(2 * (i % 8) + 1);
    end
    golden = '0;
    for (int b = 0; b < int'(BANK_COUNT); b++)
      for (int i = 0; i < int'(LANES); i++)
        golden = golden + RES_W'(32'(xv[i*DW +: DW]) * 32'(bk[b][i*DW +: DW]));

    // Reset state
    #12;
    chk_idle_outputs("reset");
    chk("reset_bankde", 64'(bankde), 64'd0);
    chk("reset_wxin", 64'(lanes_pack(Wxin)), 64'd0);
    chk("reset_wwbank", 64'(lanes_pack(Wwbank)), 64'd0);
    chk("reset_res_data", 64'(res_data), 64'd0);
    rst = 1'b1;
    tick();
    chk_idle_outputs("post_reset");

    // abort in IDLE has no effect; res_ready in IDLE ignored
    abort = 1'b1; res_ready = 1'b1;
    tick();
    abort = 1'b0; res_ready = 1'b0;
    chk_idle_outputs("idle_abort");

    // Full job, wt_valid always high
    result = RES_W'(1000);
    load_job(-1, 0);
    run_mac(RES_W'(1000));
    drain();
    chk("idle_wxin_hold", 64'(lanes_pack(Wxin)), 64'(xv));

    // Stalled load between beats 1 and 2
    result = RES_W'(1000);
    load_job(1, 3);
    run_mac(RES_W'(1000));

    // Output backpressure with start during DONE
    start = 1'b1;
    result = RES_W'(55);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_res_valid", 64'(res_valid), 64'd1);
      chk("bp_res_data", 64'(res_data), 64'd1000);
      chk("bp_busy", 64'(busy), 64'd1);
      chk("bp_wt_ready", 64'(wt_ready), 64'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_done_res_valid", 64'(res_valid), 64'd0);
    chk("bp_done_busy", 64'(busy), 64'd0);
    chk("bp_done_wt_ready", 64'(wt_ready), 64'd0);
    start = 1'b0;
    tick();
    chk_idle_outputs("bp_after");

    // Abort on the 4th mac_en cycle
    result = RES_W'(1000);
    load_job(-1, 0);
    tick();
    chk("ab_read_en", 64'(read_en), 64'd1);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("ab_mac_en", 64'(mac_en), 64'd1);
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk_idle_outputs("ab_next");
    for (int j = 0; j < int'(MAC_CYCLES); j++) begin
      tick();
      chk("ab_no_res_valid", 64'(res_valid), 64'd0);
    end
    result = RES_W'(1234);
    load_job(-1, 0);
    run_mac(RES_W'(1234));
    drain();

    // Async reset mid-LOAD, between clock edges
    start = 1'b1; x_data = xv;
    tick();
    start = 1'b0;
    wt_valid = 1'b1; wt_data = bk[0];
    tick();
    wt_data = bk[1];
    tick();
    chk("ar_pre_write_en", 64'(write_en), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_idle_outputs("ar_now");
    chk("ar_bankde", 64'(bankde), 64'd0);
    chk("ar_wxin", 64'(lanes_pack(Wxin)), 64'd0);
    chk("ar_wwbank", 64'(lanes_pack(Wwbank)), 64'd0);
    wt_valid = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    chk_idle_outputs("ar_release");

    // Clean job after reset, result stub driven with the golden MAC sum
    result = golden;
    load_job(2, 1);
    run_mac(RES_W'(14400) - RES_W'(14400) + golden);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: observed no end expected end by 200000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

endmodule
